// File: rtl/mem_read_responder_pkg.sv
// Shared constants for the memory read responder and its pipeline stages.
package mem_read_responder_pkg;

    // Data word width held by the array and carried through the pipeline.
    localparam int unsigned WORD_BITS = 16;

    // Byte-address width presented at the request port.
    localparam int unsigned ADDR_IN_BITS = 16;

    // Default word-index width (array holds 2^ADDR_BITS words).
    localparam int unsigned DEFAULT_ADDR_BITS = 10;

    // Default request-to-response latency in cycles; legal range 1..8.
    localparam int unsigned DEFAULT_LATENCY = 4;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 8;

endpackage

// File: rtl/mem_pipe_stage.sv
// One slot of the read-response pipeline: a valid bit plus a data word,
// both cleared asynchronously by reset.
module mem_pipe_stage
    import mem_read_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [WORD_BITS-1:0] data_in,
    output logic                 valid_out,
    output logic [WORD_BITS-1:0] data_out
);

    // Register the slot; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= valid_in;
            data_out  <= data_in;
        end
    end

endmodule

// File: rtl/mem_read_responder.sv
// Fully pipelined word memory: writes update the array at acceptance, reads
// sample the array at acceptance and emerge LATENCY cycles later.
module mem_read_responder
    import mem_read_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int unsigned LATENCY   = DEFAULT_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wr,
    input  logic [ADDR_IN_BITS-1:0] addr,
    input  logic [WORD_BITS-1:0]    data_in,
    output logic [WORD_BITS-1:0]    data_out,
    output logic                    data_valid
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    // Storage is intentionally not reset so contents survive rst_n.
    logic [WORD_BITS-1:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] word_idx;
    logic                 wr_accept;
    logic                 rd_accept;
    logic [WORD_BITS-1:0] rd_word;

    // Index 0 is the pipeline input; index LATENCY is the response.
    logic [LATENCY:0]     valid_chain;
    logic [WORD_BITS-1:0] data_chain [LATENCY+1];

    // Byte bit 0 and bits above the word index are don't-care (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[ADDR_IN_BITS-1:ADDR_BITS+1], addr[0]};

    assign word_idx  = addr[ADDR_BITS:1];
    assign wr_accept = enable & wr;
    assign rd_accept = enable & ~wr;
    assign rd_word   = mem[word_idx];

    // Idle cycles and writes enter the pipe as empty slots with zero data,
    // which keeps data_out at zero whenever data_valid is low.
    assign valid_chain[0] = rd_accept;
    assign data_chain[0]  = rd_accept ? rd_word : '0;

    // Array write at the acceptance edge; a read in the same edge samples
    // the old word, so later writes never disturb in-flight responses.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_idx] <= data_in;
        end
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        mem_pipe_stage u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid_in  (valid_chain[g]),
            .data_in   (data_chain[g]),
            .valid_out (valid_chain[g+1]),
            .data_out  (data_chain[g+1])
        );
    end

    assign data_valid = valid_chain[LATENCY];
    assign data_out   = data_valid ? data_chain[LATENCY] : '0;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: a vector table for the main traffic
// patterns plus hand-written read/write ordering and reset sequences.
module tb_mem_read_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    mem_read_responder #(
        .ADDR_BITS (10),
        .LATENCY   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    function automatic void add(input logic en, input logic w, input logic [15:0] a,
                                input logic [15:0] d, input logic ev, input logic [15:0] ed);
        vec_t v;
        v.en = en; v.wr = w; v.addr = a; v.din = d; v.ev = ev; v.ed = ed;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic ev, input logic [15:0] ed);
        total++;
        if (data_valid !== ev || data_out !== ed) begin
            bad++;
            $display("FAIL %s: got valid=%0b data=%04h, expected valid=%0b data=%04h",
                     name, data_valid, data_out, ev, ed);
        end
    endtask

    // Apply one request for one cycle, then settle just past the edge.
    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

        // Vector i is driven before edge i; outputs are checked just after it.
        // A read at vector r responds at vector r+3 (4 cycles after request).
        add(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000);      // v0 write
        add(1, 0, 16'h0010, 16'h0000, 0, 16'h0000);      // v1 read
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v2
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v3
        add(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF);      // v4 response
        for (int k = 0; k < 8; k++)                      // v5..v12 preload
            add(1, 1, 16'h0040 + 16'(2*k), 16'h1000 + 16'(k), 0, 16'h0000);
        for (int k = 0; k < 8; k++)                      // v13..v20 burst reads
            add(1, 0, 16'h0040 + 16'(2*k), 16'h0000, (k >= 3),
                (k >= 3) ? 16'h1000 + 16'(k - 3) : 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1005);      // v21
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1006);      // v22
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1007);      // v23
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v24
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v25
        add(1, 0, 16'h0040, 16'h0000, 0, 16'h0000);      // v26 read
        add(0, 1, 16'h0040, 16'hFFFF, 0, 16'h0000);      // v27 gated write
        add(1, 0, 16'h0042, 16'h0000, 0, 16'h0000);      // v28 read
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1000);      // v29
        add(1, 0, 16'h0044, 16'h0000, 0, 16'h0000);      // v30 read
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1001);      // v31
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v32 gap
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1002);      // v33
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v34 gap
        add(1, 0, 16'h0040, 16'h0000, 0, 16'h0000);      // v35 read (unchanged)
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v36
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v37
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1000);      // v38
        add(1, 1, 16'h0002, 16'hA5A5, 0, 16'h0000);      // v39 write word 1
        add(1, 0, 16'h0803, 16'h0000, 0, 16'h0000);      // v40 aliased read
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v41
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);      // v42
        add(0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5);      // v43

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1'b0, 16'h0000);
        rst_n = 1'b1;

        // Table: the first vector lands on the first edge with rst_n high.
        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].wr, vq[i].addr, vq[i].din);
            check($sformatf("vec%0d", i), vq[i].ev, vq[i].ed);
        end

        // Read followed by write to the same word on the next cycle.
        drive(1, 1, 16'h0020, 16'h1111);
        check("rw_pre", 1'b0, 16'h0000);
        drive(1, 0, 16'h0020, 16'h0000);
        check("rw_rd", 1'b0, 16'h0000);
        drive(1, 1, 16'h0020, 16'h2222);
        check("rw_wr", 1'b0, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        check("rw_wait", 1'b0, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        check("rw_old_data", 1'b1, 16'h1111);
        drive(1, 0, 16'h0020, 16'h0000);
        check("rw_rd2", 1'b0, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        check("rw_new_data", 1'b1, 16'h2222);

        // Reset mid-flight: three reads, two pulses seen, then reset.
        drive(1, 0, 16'h0040, 16'h0000);
        check("rst_rd0", 1'b0, 16'h0000);
        drive(1, 0, 16'h0042, 16'h0000);
        check("rst_rd1", 1'b0, 16'h0000);
        drive(1, 0, 16'h0044, 16'h0000);
        check("rst_rd2", 1'b0, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        check("rst_pulse0", 1'b1, 16'h1000);
        drive(0, 0, 16'h0000, 16'h0000);
        check("rst_pulse1", 1'b1, 16'h1001);
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", 1'b0, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        check("rst_hold", 1'b0, 16'h0000);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 16'h0000, 16'h0000);
            check($sformatf("rst_quiet%0d", c), 1'b0, 16'h0000);
        end

        // Array contents survive reset.
        drive(1, 0, 16'h0040, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        check("retain_after_reset", 1'b1, 16'h1000);
        drive(0, 0, 16'h0000, 16'h0000);
        check("retain_tail", 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
